mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage of the MiniMIPS32 pipeline. It sits directly downstream of the execute stage and consumes that stage's outputs: aluop, wa, wreg, wd, mreg, din, whilo and hilo.
- Non-memory operations pass through with one registered cycle.
- LB/LW/SB/SW run a variable-latency req/ack transaction on the data-memory port. During the transaction, upstream is stalled by deasserting in_ready.
- Registered results go to the write-back stage with a one-cycle valid pulse.

Parameters:
- ADDR_W, 32, data-memory byte-address width; dm_addr is wd[ADDR_W-1:0].

Ports:
- cpu_clk_50M  in  1  stage clock; all state updates on rising edge
- cpu_rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute-stage outputs valid this cycle
- in_ready  out  1  stage can accept; 1 only in IDLE
- mem_aluop_i  in  8  internal opcode (MINIMIPS32_* codes from defines.v)
- mem_wa_i  in  5  destination register address
- mem_wreg_i  in  1  register write enable
- mem_wd_i  in  32  ALU result; byte address for loads/stores
- mem_mreg_i  in  1  1 = load, result comes from memory
- mem_din_i  in  32  store data
- mem_whilo_i  in  1  Hi/Lo write enable
- mem_hilo_i  in  64  Hi/Lo data {hi,lo}
- dm_req  out  1  memory request, held until dm_ack
- dm_we  out  1  1 = store
- dm_wstrb  out  4  byte enables, little-endian lanes
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- dm_wdata  out  32  store data, lane-replicated
- dm_ack  in  1  request completed; dm_rdata valid same cycle for loads
- dm_rdata  in  32  load data word
- wb_valid  out  1  one-cycle pulse, write-back outputs valid
- wb_wa  out  5  destination register
- wb_wreg  out  1  register write enable, gated by wb_valid
- wb_wd  out  32  write-back data
- wb_whilo  out  1  Hi/Lo write enable, gated by wb_valid
- wb_hilo  out  64  Hi/Lo data
- mem_exc_o  out  1  misaligned-access pulse; present only with the optional feature

Behaviour:
- Reset (synchronous, high):
  - State returns to IDLE.
  - All outputs are 0, except in_ready, which is 1.
  - Reset mid-transaction drops dm_req on the next edge. No wb_valid is produced for the aborted operation; a late dm_ack after reset is ignored.
- Accept: an operation is accepted when in_valid && in_ready on a rising edge. All inputs are latched.
- FSM states: IDLE, REQ, DONE.
  - IDLE, accepted op with aluop not in {LB, LW, SB, SW}: go to DONE. wb_wd = wd; wb_hilo and wb_whilo are copied.
  - IDLE, accepted memory op: go to REQ.
  - REQ: dm_req = 1. dm_addr, dm_we, dm_wstrb and dm_wdata are stable from the first REQ cycle until ack.
  - REQ with dm_ack = 1: capture load data and go to DONE.
  - DONE: wb_valid = 1 for exactly one cycle, then return to IDLE. in_ready is 0 in REQ and DONE.
- Latency and throughput:
  - Non-memory op: accepted at edge t, wb_valid during cycle t+1.
  - Memory op: dm_req first high in cycle t+1. If ack arrives in cycle t+1+k (k >= 0), wb_valid is high in cycle t+2+k.
  - Maximum throughput is one op per 2 cycles.
- Byte lane select: b = wd[1:0].
- Loads:
  - LW: wb_wd = dm_rdata.
  - LB: wb_wd = sign-extended dm_rdata[8b+7:8b].
  - dm_we = 0, dm_wstrb = 0.
- Stores:
  - SW: dm_wstrb = 4'b1111, dm_wdata = din.
  - SB: dm_wstrb = 4'b0001 << b, dm_wdata = {4{din[7:0]}}.
  - dm_we = 1. The store's own wreg is forwarded as given (normally 0).
- mreg = 1 selects memory data for wb_wd; otherwise wb_wd is the latched wd.
- wb_wa, wb_wd and wb_hilo hold their last value after the wb_valid pulse. wb_wreg and wb_whilo are 0 whenever wb_valid = 0.
- dm_ack while not in REQ is ignored.
- The stage performs no address arithmetic. Misaligned word accesses are handled only as described under Optional Feature.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - LW/SW with wd[1:0] != 0 goes straight to DONE without any dm_req.
  - In DONE: mem_exc_o = 1, wb_wreg = 0, wb_whilo = 0, wb_valid = 1 for one cycle.
- Undefined:
  - No mem_exc_o port.
  - LW/SW ignore wd[1:0]: dm_addr = {wd[ADDR_W-1:2], 2'b00}, full word access.

Test Plan:
- Reset asserted in REQ with no ack, then deasserted; dm_ack pulsed 2 cycles later -> dm_req 0 the cycle after reset, wb_valid stays 0, in_ready 1.
- ADDIU result wd = 0x0000_0010, wa = 5, wreg = 1, accepted at edge t -> wb_valid, wb_wreg = 1, wb_wa = 5, wb_wd = 0x10 in cycle t+1; in_ready 0 in t+1, 1 in t+2.
- LW wd = 0x100, ack delayed 3 cycles with rdata 0xDEADBEEF:
  - Expect dm_req = 1 and dm_addr = 0x100 stable for 4 cycles.
  - Expect wb_wd = 0xDEADBEEF one cycle after ack.
- LB wd = 0x103, dm_rdata = 0x80FF_0000, ack same cycle as dm_req:
  - Expect wb_wd = 0xFFFF_FF80.
  - Expect wb_valid exactly 2 cycles after accept.
- SB wd = 0x202, din = 0x1234_56AB -> dm_we = 1, dm_wstrb = 4'b0100, dm_wdata = 0xABAB_ABAB, dm_addr = 0x200.
- MULT whilo = 1, hilo = 0xFFFF_FFFF_FFFF_FFFE -> wb_whilo = 1 and wb_hilo equal to the input, for one cycle only.
- With MEM_ALIGN_CHK_EN: SW wd = 0x301 -> no dm_req, and mem_exc_o = wb_valid = 1 for one cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage -- MiniMIPS32 memory-access pipeline stage.
//
// Sits behind the execute stage. Non-memory ops are registered once and
// handed to write-back. LB/LW/SB/SW run a req/ack transaction on the data
// memory port while upstream is held off via in_ready.
//
// Optional feature macro: MEM_ALIGN_CHK_EN
//   defined   -> misaligned LW/SW skip memory and raise mem_exc_o with wb_valid
//   undefined -> no mem_exc_o port; LW/SW ignore wd[1:0] (word-aligned access)
//
// Ports:
//   cpu_clk_50M, cpu_rst        clock, synchronous active-high reset
//   in_valid / in_ready         upstream handshake (in_ready = 1 only in IDLE)
//   mem_*_i                     execute-stage results latched on accept
//   dm_req/we/wstrb/addr/wdata  data-memory request, held until dm_ack
//   dm_ack, dm_rdata            memory completion and load data
//   wb_*                        write-back results, wb_valid is a 1-cycle pulse
//   mem_exc_o                   misaligned-access pulse (optional feature only)

module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        mem_aluop_i,
  input  logic [4:0]        mem_wa_i,
  input  logic              mem_wreg_i,
  input  logic [31:0]       mem_wd_i,
  input  logic              mem_mreg_i,
  input  logic [31:0]       mem_din_i,
  input  logic              mem_whilo_i,
  input  logic [63:0]       mem_hilo_i,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_wstrb,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
`ifdef MEM_ALIGN_CHK_EN
  output logic              mem_exc_o,
`endif
  output logic              wb_valid,
  output logic [4:0]        wb_wa,
  output logic              wb_wreg,
  output logic [31:0]       wb_wd,
  output logic              wb_whilo,
  output logic [63:0]       wb_hilo
);

  localparam logic [7:0] OP_LB = 8'h90;
  localparam logic [7:0] OP_LW = 8'h92;
  localparam logic [7:0] OP_SB = 8'h98;
  localparam logic [7:0] OP_SW = 8'h9A;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Fields still needed when the memory access completes.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [4:0]  wa;
    logic        wreg;
    logic [31:0] wd;
    logic        mreg;
    logic        whilo;
    logic [63:0] hilo;
  } op_t;

  state_t      state;
  op_t         op;
  logic        is_mem;
  logic        is_store;
  logic [1:0]  st_lane;
  logic [7:0]  rd_byte;
  logic [31:0] rd_word;
`ifdef MEM_ALIGN_CHK_EN
  logic        misalign;
`endif

  always_comb begin
    is_mem   = (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_LW) ||
               (mem_aluop_i == OP_SB) || (mem_aluop_i == OP_SW);
    is_store = (mem_aluop_i == OP_SB) || (mem_aluop_i == OP_SW);
    st_lane  = mem_wd_i[1:0];
    // Load lane comes from the latched address, not the live input.
    rd_byte  = dm_rdata[{op.wd[1:0], 3'b000} +: 8];
    rd_word  = (op.aluop == OP_LB) ? {{24{rd_byte[7]}}, rd_byte} : dm_rdata;
`ifdef MEM_ALIGN_CHK_EN
    misalign = ((mem_aluop_i == OP_LW) || (mem_aluop_i == OP_SW)) &&
               (mem_wd_i[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state     <= IDLE;
      op        <= '0;
      in_ready  <= 1'b1;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_wstrb  <= '0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      wb_valid  <= 1'b0;
      wb_wa     <= '0;
      wb_wreg   <= 1'b0;
      wb_wd     <= '0;
      wb_whilo  <= 1'b0;
      wb_hilo   <= '0;
`ifdef MEM_ALIGN_CHK_EN
      mem_exc_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op       <= '{mem_aluop_i, mem_wa_i, mem_wreg_i, mem_wd_i,
                          mem_mreg_i, mem_whilo_i, mem_hilo_i};
            in_ready <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
            if (misalign) begin
              // Faulting access: report it, suppress all register writes.
              state     <= DONE;
              wb_valid  <= 1'b1;
              wb_wa     <= mem_wa_i;
              wb_wreg   <= 1'b0;
              wb_wd     <= mem_wd_i;
              wb_whilo  <= 1'b0;
              wb_hilo   <= mem_hilo_i;
              mem_exc_o <= 1'b1;
            end else
`endif
            if (is_mem) begin
              state    <= REQ;
              dm_req   <= 1'b1;
              dm_we    <= is_store;
              dm_addr  <= {mem_wd_i[ADDR_W-1:2], 2'b00};
              if (mem_aluop_i == OP_SB) begin
                dm_wstrb <= 4'b0001 << st_lane;
                dm_wdata <= {4{mem_din_i[7:0]}};
              end else if (mem_aluop_i == OP_SW) begin
                dm_wstrb <= 4'b1111;
                dm_wdata <= mem_din_i;
              end else begin
                dm_wstrb <= 4'b0000;
                dm_wdata <= '0;
              end
            end else begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_wa    <= mem_wa_i;
              wb_wreg  <= mem_wreg_i;
              wb_wd    <= mem_wd_i;
              wb_whilo <= mem_whilo_i;
              wb_hilo  <= mem_hilo_i;
            end
          end
        end
        REQ: begin
          if (dm_ack) begin
            state    <= DONE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_wstrb <= '0;
            wb_valid <= 1'b1;
            wb_wa    <= op.wa;
            wb_wreg  <= op.wreg;
            wb_wd    <= op.mreg ? rd_word : op.wd;
            wb_whilo <= op.whilo;
            wb_hilo  <= op.hilo;
          end
        end
        DONE: begin
          // wb_wa/wb_wd/wb_hilo keep their value; enables drop with valid.
          state     <= IDLE;
          in_ready  <= 1'b1;
          wb_valid  <= 1'b0;
          wb_wreg   <= 1'b0;
          wb_whilo  <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
          mem_exc_o <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// ops checked against a transaction-level model of the stage.

module tb_mem_access_stage;

  localparam logic [7:0] LB = 8'h90, LW = 8'h92, SB = 8'h98, SW = 8'h9A;
  localparam logic [7:0] ADDIU = 8'h19, MULT = 8'h14, ADD = 8'h18, ANDOP = 8'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  aluop;
  logic [4:0]  wa;
  logic        wreg;
  logic [31:0] wd;
  logic        mreg;
  logic [31:0] din;
  logic        whilo;
  logic [63:0] hilo;
  logic        dm_req, dm_we, dm_ack;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_wreg, wb_whilo;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic [63:0] wb_hilo;
`ifdef MEM_ALIGN_CHK_EN
  logic        mem_exc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(.ADDR_W(32)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_aluop_i(aluop), .mem_wa_i(wa), .mem_wreg_i(wreg), .mem_wd_i(wd),
    .mem_mreg_i(mreg), .mem_din_i(din), .mem_whilo_i(whilo), .mem_hilo_i(hilo),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
`ifdef MEM_ALIGN_CHK_EN
    .mem_exc_o(mem_exc),
`endif
    .wb_valid(wb_valid), .wb_wa(wb_wa), .wb_wreg(wb_wreg), .wb_wd(wb_wd),
    .wb_whilo(wb_whilo), .wb_hilo(wb_hilo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and check it through to the return to IDLE.
  // k = cycles of dm_req before ack (ack in the (k+1)th REQ cycle).
  task automatic run_op(input logic [7:0] op, input logic [4:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] sd,
                        input logic hw, input logic [63:0] hl,
                        input int k, input logic [31:0] rdata);
    bit          mem_op, load, exc;
    int          lane;
    logic [31:0] exp_wd, exp_wdata, exp_addr, bytev;
    logic [3:0]  exp_strb;
    mem_op = (op == LB) || (op == LW) || (op == SB) || (op == SW);
    load   = (op == LB) || (op == LW);
    lane   = int'(d % 4);
    exc    = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    exc    = ((op == LW) || (op == SW)) && (lane != 0);
`endif
    // Reference results from the stage's rules
    exp_addr = d - lane;
    bytev    = (rdata / (32'd1 << (8 * lane))) % 256;
    if (op == LW)      exp_wd = rdata;
    else if (op == LB) exp_wd = (bytev >= 128) ? bytev - 32'd256 : bytev;
    else               exp_wd = d;
    if (op == SB) begin
      exp_strb  = 4'(1 << lane);
      exp_wdata = (sd % 256) * 32'h0101_0101;
    end else begin
      exp_strb  = (op == SW) ? 4'hF : 4'h0;
      exp_wdata = sd;
    end

    chk("idle_in_ready", in_ready, 1);
    aluop = op; wa = a; wreg = w; wd = d; mreg = load; din = sd;
    whilo = hw; hilo = hl; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    aluop = $urandom; wd = $urandom; din = $urandom; wa = $urandom;

    if (mem_op && !exc) begin
      for (int j = 0; j <= k; j++) begin
        chk("req", dm_req, 1);
        chk("req_addr", dm_addr, exp_addr);
        chk("req_we", dm_we, (op == SB) || (op == SW));
        chk("req_wstrb", dm_wstrb, exp_strb);
        if (op == SB || op == SW) chk("req_wdata", dm_wdata, exp_wdata);
        chk("req_wb_valid", wb_valid, 0);
        chk("req_in_ready", in_ready, 0);
        dm_ack   = (j == k);
        dm_rdata = (j == k) ? rdata : $urandom;
        step();
      end
      dm_ack = 1'b0;
      chk("done_req_low", dm_req, 0);
    end else begin
      chk("no_req", dm_req, 0);
    end

    chk("wb_valid", wb_valid, 1);
    chk("wb_in_ready", in_ready, 0);
    chk("wb_wa", wb_wa, a);
    chk("wb_wreg", wb_wreg, exc ? 0 : w);
    chk("wb_whilo", wb_whilo, exc ? 0 : hw);
    chk("wb_hilo", wb_hilo, hl);
    if (!exc) chk("wb_wd", wb_wd, exp_wd);
`ifdef MEM_ALIGN_CHK_EN
    chk("mem_exc", mem_exc, exc);
`endif
    step();
    chk("post_valid", wb_valid, 0);
    chk("post_wreg", wb_wreg, 0);
    chk("post_whilo", wb_whilo, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_wa_hold", wb_wa, a);
    if (!exc) chk("post_wd_hold", wb_wd, exp_wd);
`ifdef MEM_ALIGN_CHK_EN
    chk("post_exc", mem_exc, 0);
`endif
  endtask

  initial begin
    logic [7:0] ops [8];
    logic [7:0] op;
    ops = '{LB, LW, SB, SW, ADDIU, MULT, ADD, ANDOP};
    rst = 1'b1; in_valid = 1'b0; aluop = '0; wa = '0; wreg = 1'b0; wd = '0;
    mreg = 1'b0; din = '0; whilo = 1'b0; hilo = '0; dm_ack = 1'b0; dm_rdata = '0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_wd", wb_wd, 0);
    chk("rst_wb_hilo", wb_hilo, 0);
    chk("rst_dm_addr", dm_addr, 0);
    rst = 1'b0;
    step();

    // Reset in the middle of a transaction aborts it; late ack ignored.
    aluop = LW; wd = 32'h100; wa = 5'd3; wreg = 1'b1; mreg = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("abort_req", dm_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req_low", dm_req, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", wb_valid, 0);
    step();
    dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    step();
    dm_ack = 1'b0;
    chk("late_ack_valid", wb_valid, 0);
    chk("late_ack_req", dm_req, 0);
    chk("late_ack_ready", in_ready, 1);
    step();
    chk("late_ack_valid2", wb_valid, 0);

    // Directed cases
    run_op(ADDIU, 5'd5, 1'b1, 32'h10, 32'h0, 1'b0, 64'h0, 0, 32'h0);
    run_op(LW, 5'd7, 1'b1, 32'h100, 32'h0, 1'b0, 64'h0, 3, 32'hDEAD_BEEF);
    run_op(LB, 5'd8, 1'b1, 32'h103, 32'h0, 1'b0, 64'h0, 0, 32'h80FF_0000);
    run_op(SB, 5'd0, 1'b0, 32'h202, 32'h1234_56AB, 1'b0, 64'h0, 1, 32'h0);
    run_op(SW, 5'd0, 1'b0, 32'h300, 32'hCAFE_F00D, 1'b0, 64'h0, 2, 32'h0);
    run_op(MULT, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 32'h0);
    run_op(SW, 5'd0, 1'b0, 32'h301, 32'h5555_AAAA, 1'b0, 64'h0, 1, 32'h0);
    run_op(LW, 5'd9, 1'b1, 32'h402, 32'h0, 1'b0, 64'h0, 0, 32'h0123_4567);
    run_op(LB, 5'd10, 1'b1, 32'h500, 32'h0, 1'b0, 64'h0, 2, 32'h0000_007F);

    // Stray ack while idle does nothing
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("stray_ack_valid", wb_valid, 0);
    chk("stray_ack_req", dm_req, 0);

    // Randomized ops
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 7)];
      run_op(op, 5'($urandom), 1'($urandom), $urandom, $urandom,
             (op == MULT) ? 1'b1 : 1'($urandom),
             {$urandom, $urandom}, $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        dm_ack = 1'($urandom);
        step();
        dm_ack = 1'b0;
        chk("gap_valid", wb_valid, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
